// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM voter-session controller.
package evm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        BALLOT = 3'd2,
        COMMIT = 3'd3,
        DONE   = 3'd4,
        REJECT = 3'd5
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OK   = 2'd1;
    localparam logic [1:0] ST_DUP  = 2'd2;
    localparam logic [1:0] ST_TMO  = 2'd3;

    // UID 0 is never a valid voter.
    localparam int unsigned UID_RESERVED = 0;

endpackage

// File: rtl/voter_registry.sv
// One bit per UID recording whether that voter has already cast a vote.
module voter_registry #(
    parameter int unsigned UID_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [UID_W-1:0] set_addr,
    input  logic [UID_W-1:0] rd_addr,
    output logic             rd_hit
);

    logic [2**UID_W-1:0] voted_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            voted_q <= '0;
        end else if (set_en) begin
            voted_q[set_addr] <= 1'b1;
        end
    end

    assign rd_hit = voted_q[rd_addr];

endmodule

// File: rtl/ballot_session_ctrl.sv
// Voter session sequencer: UID entry, duplicate check, ballot window, single vote commit.
// Optional ballot-window timeout is enabled by defining BALLOT_TIMEOUT_EN.
module ballot_session_ctrl
    import evm_pkg::*;
#(
    parameter int unsigned UID_W      = 6,
    parameter int unsigned NUM_CAND   = 4,
    parameter int unsigned BALLOT_CYC = 500,
    parameter int unsigned HOLD_CYC   = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic [UID_W-1:0]    uid,
    input  logic                enter,
    input  logic [NUM_CAND-1:0] cand,
    output logic                vote_valid,
    output logic [NUM_CAND-1:0] vote_cand,
    input  logic                vote_ready,
    output logic [2:0]          state_o,
    output logic [1:0]          status,
    output logic [7:0]          voters_done,
    output logic [7:0]          led
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    if (BALLOT_CYC < 1 || HOLD_CYC < 1) begin : g_bad_param
        $error("BALLOT_CYC and HOLD_CYC must be at least 1");
    end

    state_e              state_q, state_d;
    logic                enter_q;
    logic [UID_W-1:0]    uid_q, uid_d;
    logic [NUM_CAND-1:0] cand_q, cand_d;
    logic [1:0]          status_q, status_d;
    logic [7:0]          done_q, done_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                start;
    logic                cand_onehot;
    logic                reg_hit;
    logic                reg_set;

`ifdef BALLOT_TIMEOUT_EN
    localparam int unsigned TMR_W = $clog2(BALLOT_CYC + 1);
    logic [TMR_W-1:0] timer_q, timer_d;
`endif

    assign start       = enter & ~enter_q;
    assign cand_onehot = (cand != '0) && ((cand & (cand - 1'b1)) == '0);

    voter_registry #(
        .UID_W (UID_W)
    ) u_registry (
        .clock    (clock),
        .reset    (reset),
        .set_en   (reg_set),
        .set_addr (uid_q),
        .rd_addr  (uid_q),
        .rd_hit   (reg_hit)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            enter_q  <= 1'b0;
            uid_q    <= '0;
            cand_q   <= '0;
            status_q <= ST_IDLE;
            done_q   <= '0;
            hold_q   <= '0;
`ifdef BALLOT_TIMEOUT_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            enter_q  <= enter;
            uid_q    <= uid_d;
            cand_q   <= cand_d;
            status_q <= status_d;
            done_q   <= done_d;
            hold_q   <= hold_d;
`ifdef BALLOT_TIMEOUT_EN
            timer_q  <= timer_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        uid_d    = uid_q;
        cand_d   = cand_q;
        status_d = status_q;
        done_d   = done_q;
        hold_d   = hold_q;
        reg_set  = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
        timer_d  = timer_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && !mode) begin
                    uid_d   = uid;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mode) begin
                    status_d = ST_TMO;
                    state_d  = REJECT;
                end else if (uid_q == UID_W'(UID_RESERVED) || reg_hit) begin
                    status_d = ST_DUP;
                    state_d  = REJECT;
                end else begin
                    state_d = BALLOT;
`ifdef BALLOT_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            BALLOT: begin
                // Multi-button presses fall through and are simply ignored this cycle.
                if (mode) begin
                    status_d = ST_TMO;
                    state_d  = REJECT;
                end else if (cand_onehot) begin
                    cand_d  = cand;
                    state_d = COMMIT;
                end
`ifdef BALLOT_TIMEOUT_EN
                else if (timer_q == TMR_W'(BALLOT_CYC - 1)) begin
                    status_d = ST_TMO;
                    state_d  = REJECT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
`endif
            end
            COMMIT: begin
                // mode is deliberately ignored here so an offered vote is never dropped.
                if (vote_ready) begin
                    reg_set  = 1'b1;
                    done_d   = (done_q == 8'hFF) ? done_q : done_q + 8'd1;
                    cand_d   = '0;
                    status_d = ST_OK;
                    state_d  = DONE;
                end
            end
            DONE, REJECT: begin
                if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    hold_d   = '0;
                    status_d = ST_IDLE;
                    state_d  = IDLE;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign vote_valid  = (state_q == COMMIT);
    assign vote_cand   = cand_q;
    assign state_o     = state_q;
    assign status      = status_q;
    assign voters_done = done_q;
    assign led         = {state_q, status_q, vote_valid, (state_q != IDLE), 1'b0};

endmodule
